// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, digit limit and width helper for the mm:ss timer.
package timer_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_EXPIRED} state_t;
    localparam logic [5:0] SEC_MAX = 6'd59;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/mod60_digit.sv
// mod60_digit: one modulo-60 up/down digit with saturating load and terminal-count flag.
module mod60_digit
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       ld,
    input  logic [5:0] ld_val,
    input  logic       clr,
    output logic [5:0] q,
    output logic       wrap
);
    logic [5:0] q_d, q_q;
    assign wrap = up ? (q_q == SEC_MAX) : (q_q == 6'd0);
    assign q    = q_q;
    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = 6'd0;
        else if (ld)
            q_d = (ld_val > SEC_MAX) ? SEC_MAX : ld_val;
        else if (en)
            q_d = wrap ? (up ? 6'd0 : SEC_MAX) : (up ? q_q + 6'd1 : q_q - 6'd1);
    end
    always_ff @(posedge clk) begin
        if (!reset) q_q <= 6'd0;
        else        q_q <= q_d;
    end
endmodule

// File: rtl/mmss_timer_ctrl.sv
// mmss_timer_ctrl: run/pause/expire FSM, 1 Hz prescaler and cascaded mm:ss digits.
module mmss_timer_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       clear,
    input  logic       load,
    input  logic       forward,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       running,
    output logic       finish,
    output logic       expired,
    output logic       tick
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = clog2(DIV);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            fwd_q, fwd_d, tick_q, tick_d, finish_q, finish_d;
    logic            step, ld, clr, sec_wrap, min_wrap, at_top, zero;

    mod60_digit u_sec (
        .clk(clk), .reset(reset), .en(step), .up(fwd_q), .ld(ld),
        .ld_val(set_sec), .clr(clr), .q(sec), .wrap(sec_wrap)
    );
    mod60_digit u_min (
        .clk(clk), .reset(reset), .en(step & sec_wrap), .up(fwd_q), .ld(ld),
        .ld_val(set_min), .clr(clr), .q(min), .wrap(min_wrap)
    );

    assign at_top = (presc_q == PW'(DIV - 1));
    assign zero   = (min == 6'd0) && (sec == 6'd0);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        fwd_d    = (state_q == ST_IDLE) ? forward : fwd_q;
        ld       = 1'b0;
        clr      = 1'b0;
        step     = 1'b0;
        finish_d = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            clr     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (forward || !zero) begin
                            state_d = ST_RUN;
                            presc_d = '0;
                        end
                    end else begin
                        ld = load;
                    end
                end
                ST_RUN: begin
                    step     = at_top;
                    presc_d  = at_top ? '0 : presc_q + PW'(1);
                    finish_d = at_top & (fwd_q ? (sec_wrap & min_wrap)
                                               : (min == 6'd0 && sec == 6'd1));
                    // expiry beats a same-cycle pause so a countdown never resumes from 00:00
                    state_d  = (finish_d && !fwd_q) ? ST_EXPIRED : (start ? ST_PAUSE : ST_RUN);
                end
                ST_PAUSE: state_d = start ? ST_RUN : ST_PAUSE;
                ST_EXPIRED: begin
                    if (start) begin
                        state_d = ST_IDLE;
                    end else if (load) begin
                        state_d = ST_IDLE;
                        ld      = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        tick_d = step;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            fwd_q    <= 1'b1;
            tick_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            fwd_q    <= fwd_d;
            tick_q   <= tick_d;
            finish_q <= finish_d;
        end
    end

    assign running = (state_q == ST_RUN);
    assign expired = (state_q == ST_EXPIRED);
    assign tick    = tick_q;
    assign finish  = finish_q;
endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// tb_mmss_timer_ctrl: directed + random stimulus, seconds-count reference model and tick scoreboard.
module tb_mmss_timer_ctrl;
    localparam int DIV = 10;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, clear = 1'b0, load = 1'b0, forward = 1'b1;
    logic [5:0] set_min = '0, set_sec = '0;
    logic [5:0] min, sec;
    logic       running, finish, expired, tick;

    int total = 0;
    int bad = 0;

    int t = 0, frac = 0, st = M_IDLE;
    bit up = 1'b1;
    logic [14:0] sbq[$];

    mmss_timer_ctrl #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .load(load),
        .forward(forward), .set_min(set_min), .set_sec(set_sec), .min(min), .sec(sec),
        .running(running), .finish(finish), .expired(expired), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > 59) ? 59 : v;
    endfunction

    task automatic model_step();
        bit tk, fin;
        tk = 0;
        fin = 0;
        if (!reset) begin
            st = M_IDLE; t = 0; frac = 0; up = 1'b1;
            return;
        end
        if (st == M_IDLE) up = forward;
        if (clear) begin
            st = M_IDLE; t = 0; frac = 0;
            return;
        end
        case (st)
            M_IDLE: begin
                if (start) begin
                    if (forward || t != 0) begin st = M_RUN; frac = 0; end
                end else if (load) begin
                    t = sat(int'(set_min)) * 60 + sat(int'(set_sec));
                end
            end
            M_RUN: begin
                frac++;
                if (frac == DIV) begin
                    frac = 0;
                    tk = 1;
                    if (up) begin
                        t = (t + 1) % 3600;
                        fin = (t == 0);
                    end else begin
                        t = t - 1;
                        fin = (t == 0);
                        if (fin) st = M_EXP;
                    end
                end
                if (start && st == M_RUN) st = M_PAUSE;
            end
            M_PAUSE: if (start) st = M_RUN;
            default: begin
                if (start) st = M_IDLE;
                else if (load) begin
                    t = sat(int'(set_min)) * 60 + sat(int'(set_sec));
                    st = M_IDLE;
                end
            end
        endcase
        if (tk) sbq.push_back({6'(t / 60), 6'(t % 60), fin, st == M_RUN, st == M_EXP});
    endtask

    task automatic cyc(input bit s, input bit c, input bit l);
        start = s; clear = c; load = l;
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cyc(0, 0, 0);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_min"}, int'(min), t / 60);
        chk({tag, "_sec"}, int'(sec), t % 60);
        chk({tag, "_running"}, int'(running), int'(st == M_RUN));
        chk({tag, "_expired"}, int'(expired), int'(st == M_EXP));
    endtask

    always @(negedge clk) begin
        logic [14:0] e;
        if (tick === 1'b1) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL tick_unexpected: got %h want none", {min, sec, finish, running, expired});
            end else begin
                e = sbq.pop_front();
                if ({min, sec, finish, running, expired} !== e) begin
                    bad++;
                    $display("FAIL tick_step: got %h want %h", {min, sec, finish, running, expired}, e);
                end
            end
        end else if (finish === 1'b1) begin
            total++;
            bad++;
            $display("FAIL finish_no_tick: got 1 want 0");
        end
    end

    initial begin
        repeat (3) cyc(1, 0, 0);
        chk_all("reset");
        chk("reset_tick", int'(tick), 0);
        reset = 1'b1;
        cyc(1, 0, 0);
        chk_all("reset_start");

        forward = 1'b1;
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        chk_all("up_start");
        run(3600 * DIV);
        chk_all("up_wrap");

        cyc(0, 1, 0);
        chk_all("clear1");
        forward = 1'b0;
        set_min = 6'd1; set_sec = 6'd2;
        cyc(0, 0, 1);
        chk_all("cd_load");
        cyc(1, 0, 0);
        run(62 * DIV + 5);
        chk_all("cd_expired");
        run(50);
        chk_all("cd_hold");

        cyc(0, 1, 0);
        forward = 1'b1;
        cyc(1, 0, 0);
        run(4);
        cyc(1, 0, 0);
        chk_all("paused");
        run(20);
        chk_all("pause_hold");
        cyc(1, 0, 0);
        run(15);
        chk_all("resumed");

        cyc(0, 1, 0);
        cyc(1, 0, 0);
        run(DIV - 1);
        cyc(1, 1, 0);
        chk_all("clear_on_tick");
        forward = 1'b0;
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk_all("cd_zero_start");

        set_min = 6'd45; set_sec = 6'd61;
        cyc(0, 0, 1);
        chk_all("load_sat");
        forward = 1'b1;
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        forward = 1'b0;
        run(5 * DIV);
        chk_all("mode_lock");
        cyc(0, 1, 0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) forward = ~forward;
            set_min = 6'($urandom_range(0, 63));
            set_sec = 6'($urandom_range(0, 63));
            cyc($urandom_range(0, 29) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0);
            if (i % 97 == 0) chk_all("rand");
        end

        run(3);
        chk("sb_drain", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
